// File: rtl/pll_reset_sequencer.sv
// PLL bring-up and staged reset release: PLL reset pulse, lock wait with retry, lock
// qualification, codec then DSP release. Optional macro: SYSMGR_LOCK_RECOVERY_EN.
module pll_reset_sequencer #(
    parameter int unsigned PLL_RST_CYCLES      = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 128,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 4096,
    parameter int unsigned MAX_RETRIES         = 3,
    parameter int unsigned STAGE_GAP           = 64
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       pll_lock,
    input  logic       soft_reset_req,
    output logic       pll_reset,
    output logic       rst_codec,
    output logic       rst_dsp,
    output logic       ready,
    output logic       fault,
    output logic [3:0] retry_count,
    output logic       lock_lost
);

    typedef enum logic [2:0] {
        S_PLLRST, S_WAIT_LOCK, S_STABLE, S_REL_CODEC, S_RUN, S_FAULT
    } state_t;

    localparam logic [15:0] C_PLL_LAST = 16'(PLL_RST_CYCLES - 1);
    localparam logic [15:0] C_STB_LAST = 16'(LOCK_STABLE_CYCLES - 1);
    localparam logic [15:0] C_TO_LAST  = 16'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [15:0] C_GAP_LAST = 16'(STAGE_GAP - 1);
    localparam logic [3:0]  C_MAX      = 4'(MAX_RETRIES);

    state_t      r_state, w_state_nx;
    logic [15:0] r_cnt, w_cnt_nx;
    logic [1:0]  r_sync;
    logic        r_pll_reset, r_rst_codec, r_rst_dsp, r_ready, r_fault, r_lock_lost;
    logic [3:0]  r_retry;
    logic        w_pll_reset_nx, w_rst_codec_nx, w_rst_dsp_nx, w_ready_nx, w_fault_nx;
    logic        w_lock_lost_nx;
    logic [3:0]  w_retry_nx, w_retry_inc;
    logic        w_lock_s;

    assign w_lock_s    = r_sync[1];
    assign w_retry_inc = (r_retry == 4'hF) ? r_retry : r_retry + 4'd1;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state     <= S_PLLRST;
            r_cnt       <= '0;
            r_sync      <= '0;
            r_pll_reset <= 1'b1;
            r_rst_codec <= 1'b1;
            r_rst_dsp   <= 1'b1;
            r_ready     <= 1'b0;
            r_fault     <= 1'b0;
            r_retry     <= '0;
            r_lock_lost <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            r_sync      <= {r_sync[0], pll_lock};
            r_pll_reset <= w_pll_reset_nx;
            r_rst_codec <= w_rst_codec_nx;
            r_rst_dsp   <= w_rst_dsp_nx;
            r_ready     <= w_ready_nx;
            r_fault     <= w_fault_nx;
            r_retry     <= w_retry_nx;
            r_lock_lost <= w_lock_lost_nx;
        end
    end

    // Outputs are computed as next-state values so every output comes straight from a flop.
    always_comb begin
        w_state_nx     = r_state;
        w_cnt_nx       = r_cnt;
        w_pll_reset_nx = r_pll_reset;
        w_rst_codec_nx = r_rst_codec;
        w_rst_dsp_nx   = r_rst_dsp;
        w_ready_nx     = r_ready;
        w_fault_nx     = r_fault;
        w_retry_nx     = r_retry;
        w_lock_lost_nx = r_lock_lost;

        if (soft_reset_req) begin
            w_state_nx     = S_PLLRST;
            w_cnt_nx       = '0;
            w_pll_reset_nx = 1'b1;
            w_rst_codec_nx = 1'b1;
            w_rst_dsp_nx   = 1'b1;
            w_ready_nx     = 1'b0;
            w_fault_nx     = 1'b0;
            w_retry_nx     = '0;
            w_lock_lost_nx = 1'b0;
        end else begin
            case (r_state)
                S_PLLRST: begin
                    if (r_cnt == C_PLL_LAST) begin
                        w_state_nx     = S_WAIT_LOCK;
                        w_cnt_nx       = '0;
                        w_pll_reset_nx = 1'b0;
                    end else begin
                        w_cnt_nx = r_cnt + 16'd1;
                    end
                end
                S_WAIT_LOCK: begin
                    if (w_lock_s) begin
                        w_state_nx = S_STABLE;
                        w_cnt_nx   = '0;
                    end else if (r_cnt == C_TO_LAST) begin
                        w_cnt_nx       = '0;
                        w_pll_reset_nx = 1'b1;
                        if (r_retry < C_MAX) begin
                            w_state_nx = S_PLLRST;
                            w_retry_nx = w_retry_inc;
                        end else begin
                            w_state_nx = S_FAULT;
                            w_fault_nx = 1'b1;
                        end
                    end else begin
                        w_cnt_nx = r_cnt + 16'd1;
                    end
                end
                S_STABLE: begin
                    if (!w_lock_s) begin
                        w_state_nx = S_WAIT_LOCK;
                        w_cnt_nx   = '0;
                    end else if (r_cnt == C_STB_LAST) begin
                        w_state_nx     = S_REL_CODEC;
                        w_cnt_nx       = '0;
                        w_rst_codec_nx = 1'b0;
                    end else begin
                        w_cnt_nx = r_cnt + 16'd1;
                    end
                end
                S_REL_CODEC: begin
                    if (!w_lock_s) begin
                        w_state_nx     = S_WAIT_LOCK;
                        w_cnt_nx       = '0;
                        w_rst_codec_nx = 1'b1;
                    end else if (r_cnt == C_GAP_LAST) begin
                        w_state_nx   = S_RUN;
                        w_cnt_nx     = '0;
                        w_rst_dsp_nx = 1'b0;
                        w_ready_nx   = 1'b1;
                        w_retry_nx   = '0;
                    end else begin
                        w_cnt_nx = r_cnt + 16'd1;
                    end
                end
                S_RUN: begin
                    if (!w_lock_s) begin
                        w_cnt_nx       = '0;
                        w_pll_reset_nx = 1'b1;
                        w_rst_codec_nx = 1'b1;
                        w_rst_dsp_nx   = 1'b1;
                        w_ready_nx     = 1'b0;
                        w_lock_lost_nx = 1'b1;
`ifdef SYSMGR_LOCK_RECOVERY_EN
                        w_state_nx     = S_PLLRST;
`else
                        w_state_nx     = S_FAULT;
                        w_fault_nx     = 1'b1;
`endif
                    end
                end
                S_FAULT: begin
                    w_pll_reset_nx = 1'b1;
                    w_rst_codec_nx = 1'b1;
                    w_rst_dsp_nx   = 1'b1;
                    w_ready_nx     = 1'b0;
                    w_fault_nx     = 1'b1;
                end
                default: begin
                    w_state_nx     = S_PLLRST;
                    w_cnt_nx       = '0;
                    w_pll_reset_nx = 1'b1;
                    w_rst_codec_nx = 1'b1;
                    w_rst_dsp_nx   = 1'b1;
                    w_ready_nx     = 1'b0;
                end
            endcase
        end
    end

    assign pll_reset   = r_pll_reset;
    assign rst_codec   = r_rst_codec;
    assign rst_dsp     = r_rst_dsp;
    assign ready       = r_ready;
    assign fault       = r_fault;
    assign retry_count = r_retry;
    assign lock_lost   = r_lock_lost;

endmodule
